// File: rtl/mem_arbiter_n_pkg.sv
// Shared definitions for the N-master memory arbiter: FSM encoding,
// arbitration mode constants and width helpers.
package mem_arbiter_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } arb_state_t;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 30; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Pointer and counter registers always need at least one bit.
    function automatic int width_f(input int value);
        return (clog2_f(value) < 1) ? 1 : clog2_f(value);
    endfunction

endpackage

// File: rtl/mem_arbiter_n_rr_select.sv
// Combinational request selector: fixed priority (lowest index) or
// round-robin search starting at the supplied pointer.
module rr_select
    import mem_arbiter_n_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int PTR_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    input  logic                   mode,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [PTR_W-1:0]       grant_idx,
    output logic                   grant_any
);

    int start_s;
    int cand_s;

    // Walk the request vector once from the start index, first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand_s    = 0;
        start_s   = (mode == ARB_RR) ? int'(ptr) : 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand_s = start_s + k;
            if (cand_s >= NUM_MASTERS) begin
                cand_s = cand_s - NUM_MASTERS;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_any && req[cand_s]) begin
                grant_any      = 1'b1;
                grant[cand_s]  = 1'b1;
                grant_idx      = PTR_W'(cand_s);
            end else begin
                grant_any = grant_any;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-master to single-slave memory arbiter with fixed or round-robin priority,
// slave wait states via PREADY and a timeout error completion.
module mem_arbiter_n
    import mem_arbiter_n_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int RR_MODE     = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_stall,
    output logic [NUM_MASTERS-1:0]        m_done,
    output logic                          m_err,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          PSEL,
    output logic                          PWRITE,
    output logic [ADDR_W-1:0]             PADDR,
    output logic [DATA_W-1:0]             PWDATA,
    input  logic                          PREADY,
    input  logic [DATA_W-1:0]             PRDATA
);

    localparam int PTR_W = width_f(NUM_MASTERS);
    localparam int CNT_W = width_f(TIMEOUT + 1);
    localparam logic ARB_MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

    arb_state_t             state_r;
    logic [PTR_W-1:0]       winner_r;
    logic [PTR_W-1:0]       rr_ptr_r;
    logic [CNT_W-1:0]       wait_cnt_r;

    logic [NUM_MASTERS-1:0] grant_s;
    logic [PTR_W-1:0]       grant_idx_s;
    logic                   grant_any_s;
    logic [NUM_MASTERS-1:0] winner_oh_s;
    logic                   others_pending_s;
    logic                   launch_s;
    logic                   timeout_hit_s;
    logic [PTR_W-1:0]       rr_next_s;
    logic                   sel_write_s;
    logic [ADDR_W-1:0]      sel_addr_s;
    logic [DATA_W-1:0]      sel_wdata_s;

    rr_select #(
        .NUM_MASTERS (NUM_MASTERS),
        .PTR_W       (PTR_W)
    ) u_rr_select (
        .req       (m_req),
        .ptr       (rr_ptr_r),
        .mode      (ARB_MODE),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // One-hot of the master currently owning (or just finished with) the slave.
    always_comb begin
        winner_oh_s           = '0;
        winner_oh_s[winner_r] = 1'b1;
    end

    // Arbitration qualifiers, timeout detect and the request mux of the candidate winner.
    always_comb begin
        others_pending_s = |(m_req & ~winner_oh_s);
        timeout_hit_s    = (wait_cnt_r == CNT_W'(TIMEOUT - 1));
        sel_write_s      = m_write[grant_idx_s];
        sel_addr_s       = m_addr[int'(grant_idx_s) * ADDR_W +: ADDR_W];
        sel_wdata_s      = m_wdata[int'(grant_idx_s) * DATA_W +: DATA_W];
        if (state_r == ST_IDLE) begin
            launch_s = grant_any_s;
        end else if (state_r == ST_COMPLETE) begin
            launch_s = others_pending_s;
        end else begin
            launch_s = 1'b0;
        end
    end

    // Round-robin pointer advances past the served master; frozen in fixed mode.
    always_comb begin
        if (ARB_MODE == ARB_RR) begin
            if (int'(winner_r) == NUM_MASTERS - 1) begin
                rr_next_s = '0;
            end else begin
                rr_next_s = winner_r + PTR_W'(1);
            end
        end else begin
            rr_next_s = rr_ptr_r;
        end
    end

    // Stall until the completion pulse releases the master.
    assign m_stall = m_req & ~m_done;

    // Main FSM with registered slave-side and master-side outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r    <= ST_IDLE;
            winner_r   <= '0;
            rr_ptr_r   <= '0;
            wait_cnt_r <= '0;
            PSEL       <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            m_done     <= '0;
            m_err      <= 1'b0;
            m_rdata    <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_COMPLETE: begin
                    m_done <= '0;
                    m_err  <= 1'b0;
                    if (launch_s) begin
                        state_r    <= ST_ACCESS;
                        PSEL       <= 1'b1;
                        winner_r   <= grant_idx_s;
                        PWRITE     <= sel_write_s;
                        PADDR      <= sel_addr_s;
                        PWDATA     <= sel_wdata_s;
                        wait_cnt_r <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        state_r  <= ST_COMPLETE;
                        PSEL     <= 1'b0;
                        m_done   <= winner_oh_s;
                        m_err    <= 1'b0;
                        rr_ptr_r <= rr_next_s;
                        if (!PWRITE) begin
                            m_rdata <= PRDATA;
                        end else begin
                            m_rdata <= m_rdata;
                        end
                    end else if (timeout_hit_s) begin
                        // Slave never answered: close the access with an error.
                        state_r    <= ST_COMPLETE;
                        PSEL       <= 1'b0;
                        m_done     <= winner_oh_s;
                        m_err      <= 1'b1;
                        m_rdata    <= '0;
                        rr_ptr_r   <= rr_next_s;
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    PSEL    <= 1'b0;
                    m_done  <= '0;
                    m_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Self-checking bench: round-robin and fixed-priority arbiters driven by directed
// and randomized transactions, checked against a transaction-level model.
module tb_mem_arbiter_n;

    localparam int N   = 4;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int TO0 = 15;
    localparam int TO1 = 4;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic [N-1:0]    req_s    [2];
    logic [N-1:0]    wr_s     [2];
    logic [N*AW-1:0] addr_s   [2];
    logic [N*DW-1:0] wdata_s  [2];
    logic            pready_s [2];
    logic [DW-1:0]   prdata_s [2];
    logic [N-1:0]    stall_s  [2];
    logic [N-1:0]    done_s   [2];
    logic            err_s    [2];
    logic [DW-1:0]   rdata_s  [2];
    logic            psel_s   [2];
    logic            pwrite_s [2];
    logic [AW-1:0]   paddr_s  [2];
    logic [DW-1:0]   pwdata_s [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: round-robin pointer and last returned read data per DUT.
    int            ptr_m   [2];
    logic [DW-1:0] rdata_m [2];

    mem_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(TO0)) u_rr (
        .CLK(CLK), .RESET(RESET), .m_req(req_s[0]), .m_write(wr_s[0]), .m_addr(addr_s[0]),
        .m_wdata(wdata_s[0]), .m_stall(stall_s[0]), .m_done(done_s[0]), .m_err(err_s[0]),
        .m_rdata(rdata_s[0]), .PSEL(psel_s[0]), .PWRITE(pwrite_s[0]), .PADDR(paddr_s[0]),
        .PWDATA(pwdata_s[0]), .PREADY(pready_s[0]), .PRDATA(prdata_s[0]));

    mem_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(TO1)) u_fx (
        .CLK(CLK), .RESET(RESET), .m_req(req_s[1]), .m_write(wr_s[1]), .m_addr(addr_s[1]),
        .m_wdata(wdata_s[1]), .m_stall(stall_s[1]), .m_done(done_s[1]), .m_err(err_s[1]),
        .m_rdata(rdata_s[1]), .PSEL(psel_s[1]), .PWRITE(pwrite_s[1]), .PADDR(paddr_s[1]),
        .PWDATA(pwdata_s[1]), .PREADY(pready_s[1]), .PRDATA(prdata_s[1]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int tmo(input int d);
        return (d == 0) ? TO0 : TO1;
    endfunction

    // Spec rule: search from the pointer (RR) or from 0 (fixed), first requester wins.
    function automatic int pick(input int d, input logic [N-1:0] r);
        int start;
        start = (d == 0) ? ptr_m[0] : 0;
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    task automatic randomize_master(input int d, input int m);
        addr_s[d][m*AW +: AW]  = {$urandom, $urandom};
        wdata_s[d][m*DW +: DW] = {$urandom, $urandom};
        wr_s[d][m]             = 1'($urandom_range(0, 1));
    endtask

    // Called at the falling edge of the first ACCESS cycle; returns at the COMPLETE cycle.
    task automatic do_access(input int d, input int w, input logic [DW-1:0] rd, output int win);
        logic [N-1:0] oh;
        bit timed;
        int len;
        win   = pick(d, req_s[d]);
        timed = (w >= tmo(d));
        len   = timed ? tmo(d) : w + 1;
        oh    = '0;
        oh[win] = 1'b1;
        for (int c = 0; c < len; c++) begin
            chk("acc_psel", psel_s[d], 1'b1);
            chk("acc_paddr", paddr_s[d], addr_s[d][win*AW +: AW]);
            chk("acc_pwdata", pwdata_s[d], wdata_s[d][win*DW +: DW]);
            chk("acc_pwrite", pwrite_s[d], wr_s[d][win]);
            chk("acc_done", done_s[d], '0);
            chk("acc_stall", stall_s[d], req_s[d]);
            pready_s[d] = (!timed && c == w);
            prdata_s[d] = (c == w) ? rd : {$urandom, $urandom};
            @(negedge CLK);
        end
        if (d == 0) ptr_m[0] = (win + 1) % N;
        if (timed) rdata_m[d] = '0;
        else if (!wr_s[d][win]) rdata_m[d] = rd;
        chk("cpl_done", done_s[d], oh);
        chk("cpl_err", err_s[d], timed);
        chk("cpl_rdata", rdata_s[d], rdata_m[d]);
        chk("cpl_psel", psel_s[d], 1'b0);
        chk("cpl_stall", stall_s[d], req_s[d] & ~oh);
        pready_s[d] = 1'($urandom_range(0, 1));
        prdata_s[d] = {$urandom, $urandom};
    endtask

    // Hold request set r for ntx completions, then drop all requests.
    task automatic round(input int d, input logic [N-1:0] r, input int ntx, input bit rnd_wait, input int fixed_w);
        int win;
        int w;
        req_s[d] = r;
        for (int m = 0; m < N; m++) randomize_master(d, m);
        @(negedge CLK);
        for (int t = 0; t < ntx; t++) begin
            if (rnd_wait) w = ($urandom_range(0, 7) == 0) ? tmo(d) + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
            else w = fixed_w;
            do_access(d, w, {$urandom, $urandom}, win);
            if (t == ntx - 1) begin
                req_s[d]    = '0;
                pready_s[d] = 1'b0;
            end else begin
                randomize_master(d, win);
            end
            @(negedge CLK);
            if (t < ntx - 1 && ((r & ~(N'(1) << win)) == '0)) begin
                chk("idle_psel", psel_s[d], 1'b0);
                chk("idle_done", done_s[d], '0);
                @(negedge CLK);
            end
        end
        chk("end_psel", psel_s[d], 1'b0);
        chk("end_done", done_s[d], '0);
    endtask

    initial begin
        int win;
        RESET = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_s[d] = '0; wr_s[d] = '0; addr_s[d] = '0; wdata_s[d] = '0;
            pready_s[d] = 1'b0; prdata_s[d] = '0;
            ptr_m[d] = 0; rdata_m[d] = '0;
        end
        @(negedge CLK);
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            chk("rst_psel", psel_s[d], 1'b0);
            chk("rst_pwrite", pwrite_s[d], 1'b0);
            chk("rst_paddr", paddr_s[d], '0);
            chk("rst_pwdata", pwdata_s[d], '0);
            chk("rst_done", done_s[d], '0);
            chk("rst_err", err_s[d], 1'b0);
            chk("rst_rdata", rdata_s[d], '0);
        end
        RESET = 1'b1;
        @(negedge CLK);

        // RR, all masters requesting, zero wait states: grants 0,1,2,3,0.
        round(0, 4'b1111, 5, 1'b0, 0);

        // Single read by master 0 with one-cycle slave response.
        req_s[0] = 4'b0001;
        wr_s[0][0] = 1'b0;
        addr_s[0][0 +: AW] = 64'h100;
        @(negedge CLK);
        do_access(0, 0, 64'hDEAD, win);
        chk("read_dead", rdata_s[0], 64'hDEAD);
        req_s[0] = '0;
        @(negedge CLK);

        // Write 0xCAFE to 0x200 by master 1 with two wait states.
        req_s[0] = 4'b0010;
        wr_s[0][1] = 1'b1;
        addr_s[0][1*AW +: AW]  = 64'h200;
        wdata_s[0][1*DW +: DW] = 64'hCAFE;
        @(negedge CLK);
        do_access(0, 2, {$urandom, $urandom}, win);
        chk("write_keeps_rdata", rdata_s[0], 64'hDEAD);
        req_s[0] = '0;
        @(negedge CLK);

        // Slave never ready: timeout after TIMEOUT access cycles, read data cleared.
        req_s[0] = 4'b0100;
        wr_s[0][2] = 1'b0;
        @(negedge CLK);
        do_access(0, TO0 + 3, {$urandom, $urandom}, win);
        req_s[0] = '0;
        @(negedge CLK);

        // Fixed priority, masters 1 and 3 held: master 1 served every time.
        round(1, 4'b1010, 4, 1'b1, 0);

        // Randomized rounds on both arbiters.
        for (int i = 0; i < 14; i++) begin
            round(i % 2, N'($urandom_range(1, 15)), int'($urandom_range(1, 5)), 1'b1, 0);
        end

        // Reset asserted in the middle of an access aborts it without a done pulse.
        req_s[0] = 4'b0100;
        randomize_master(0, 2);
        pready_s[0] = 1'b0;
        @(negedge CLK);
        chk("pre_abort_psel", psel_s[0], 1'b1);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk("abort_psel", psel_s[0], 1'b0);
        chk("abort_done", done_s[0], '0);
        chk("abort_paddr", paddr_s[0], '0);
        chk("abort_rdata", rdata_s[0], '0);
        req_s[0] = '0;
        @(negedge CLK);
        RESET = 1'b1;
        ptr_m[0] = 0;
        rdata_m[0] = '0;
        rdata_m[1] = '0;
        @(negedge CLK);
        chk("post_rst_psel", psel_s[0], 1'b0);
        chk("post_rst_done", done_s[0], '0);
        round(0, 4'b1111, 2, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
